bus_mem_arbiter: RTL and testbench

- N-requester successor to the single-master bus-to-memory port.
- Accepts up to CPUS independent word requests (read or write), arbitrates fixed-priority or round-robin, and issues one transaction at a time on the single data-memory port (dREN/dWEN/daddr/dstore, dwait/dload).
- Adds per-transaction latching, requester fairness and a dwait watchdog.
- Sits between the cache-side bus controller and RAM.

---
 rtl/cpu_types_pkg.sv | 22 ++
 rtl/bus_arb_if.sv | 48 ++++
 rtl/rr_picker.sv | 48 ++++
 rtl/bus_mem_arbiter.sv | 136 +++++++++++++
 tb/tb_bus_mem_arbiter.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types for the bus-to-memory arbitration path.
// Contents:
//   word_t        32-bit data/address word
//   arb_state_t   arbiter FSM states
//   mem_op_t      latched memory operation
//   TIMEOUT_DATA  read data returned to a requester whose access was aborted
//   idx_width()   width of an index over n items, never less than 1
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {ARB_IDLE, ARB_ACCESS} arb_state_t;

    typedef enum logic {OP_READ, OP_WRITE} mem_op_t;

    localparam word_t TIMEOUT_DATA = 32'hBAD1BAD1;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bus_arb_if.sv
// Signal bundle between the cache-side requesters, the arbiter and the
// single data-memory port.
// Modports:
//   arb    the arbiter: takes requests and memory status, drives responses
//          and memory commands
//   cache  the requesters: drive cREN/cWEN/caddr/cstore, see cwait/cload
//   mem    the memory: sees dREN/dWEN/daddr/dstore, drives dwait/dload
interface bus_arb_if #(
    parameter int CPUS = 2
);
    localparam int GW = cpu_types_pkg::idx_width(CPUS);

    // requester side
    logic [CPUS-1:0]                 cREN;
    logic [CPUS-1:0]                 cWEN;
    cpu_types_pkg::word_t [CPUS-1:0] caddr;
    cpu_types_pkg::word_t [CPUS-1:0] cstore;
    logic [CPUS-1:0]                 cwait;
    cpu_types_pkg::word_t [CPUS-1:0] cload;

    // memory side
    logic                 dREN;
    logic                 dWEN;
    cpu_types_pkg::word_t daddr;
    cpu_types_pkg::word_t dstore;
    logic                 dwait;
    cpu_types_pkg::word_t dload;

    // status
    logic [GW-1:0] grant;
    logic          timeout_err;

    modport arb (
        input  cREN, cWEN, caddr, cstore, dwait, dload,
        output cwait, cload, dREN, dWEN, daddr, dstore, grant, timeout_err
    );

    modport cache (
        output cREN, cWEN, caddr, cstore,
        input  cwait, cload, grant
    );

    modport mem (
        input  dREN, dWEN, daddr, dstore,
        output dwait, dload
    );

endinterface

// File: rtl/rr_picker.sv
// Combinational rotating-priority picker.
// Ports:
//   req    in  N  request vector
//   start  in  W  index with highest priority this cycle (must be < N)
//   idx    out W  winning index (first requester at or after start, wrapping)
//   valid  out 1  at least one request present
// With start tied to 0 this is a plain lowest-index-wins priority encoder.
module rr_picker #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] start,
    output logic [W-1:0] idx,
    output logic         valid
);

    // Requests at or above the start pointer take precedence; if none exist
    // the search wraps around to the lowest requesting index.
    logic [N-1:0] hi_req;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_hi
            assign hi_req[gi] = req[gi] && (gi >= int'(start));
        end
    endgenerate

    logic [W-1:0] lo_idx;
    logic [W-1:0] hi_idx;

    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        // Descending scan so the lowest set bit is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                lo_idx = W'(i);
            end
            if (hi_req[i]) begin
                hi_idx = W'(i);
            end
        end
    end

    assign valid = |req;
    assign idx   = (|hi_req) ? hi_idx : lo_idx;

endmodule

// File: rtl/bus_mem_arbiter.sv
// Multi-requester front end for a single data-memory port.
// Accepts word read/write requests from CPUS channels, picks one
// (round-robin or fixed priority), latches its command and runs it on the
// memory port until dwait drops or the optional watchdog expires.
// Ports:
//   CLK  in  clock, rising edge
//   RST  in  asynchronous active-high reset
//   bus  arb modport of bus_arb_if: requests/responses, memory port,
//        grant and timeout_err status
// Parameters:
//   CPUS     number of requesting channels (>= 1)
//   RR_MODE  1 = round-robin, 0 = lowest index wins
//   TIMEOUT  cycles of continuous dwait in ACCESS before abort, 0 = off
module bus_mem_arbiter #(
    parameter int CPUS    = 2,
    parameter int RR_MODE = 1,
    parameter int TIMEOUT = 0
) (
    input logic    CLK,
    input logic    RST,
    bus_arb_if.arb bus
);
    import cpu_types_pkg::*;

    localparam int GW   = idx_width(CPUS);
    localparam int TMAX = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int TW   = idx_width(TMAX + 1);

    arb_state_t    state_reg;
    logic [GW-1:0] grant_reg;
    logic [GW-1:0] rr_ptr_reg;
    mem_op_t       op_reg;
    word_t         addr_reg;
    word_t         data_reg;
    logic [TW-1:0] timer_reg;

    logic [CPUS-1:0] req;
    logic [GW-1:0]   start;
    logic [GW-1:0]   win_idx;
    logic            win_valid;
    logic            in_access;
    logic            done;
    logic            abort;
    logic            finish;
    logic [GW-1:0]   next_ptr;

    generate
        for (genvar gi = 0; gi < CPUS; gi++) begin : g_req
            assign req[gi] = bus.cREN[gi] | bus.cWEN[gi];
        end
    endgenerate

    assign start = (RR_MODE != 0) ? rr_ptr_reg : '0;

    rr_picker #(
        .N (CPUS),
        .W (GW)
    ) u_picker (
        .req   (req),
        .start (start),
        .idx   (win_idx),
        .valid (win_valid)
    );

    assign in_access = (state_reg == ARB_ACCESS);
    assign done      = in_access && !bus.dwait;
    // Abort only while dwait is still high, so a completion landing on the
    // last allowed cycle is treated as a normal completion.
    assign abort     = (TIMEOUT > 0) && in_access && bus.dwait
                       && (timer_reg == TW'(TMAX));
    assign finish    = done || abort;
    assign next_ptr  = (grant_reg == GW'(CPUS - 1)) ? '0 : grant_reg + 1'b1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg  <= ARB_IDLE;
            grant_reg  <= '0;
            rr_ptr_reg <= '0;
            op_reg     <= OP_READ;
            addr_reg   <= '0;
            data_reg   <= '0;
            timer_reg  <= '0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (win_valid) begin
                        // A channel asserting both enables is treated as a write.
                        grant_reg <= win_idx;
                        op_reg    <= bus.cWEN[win_idx] ? OP_WRITE : OP_READ;
                        addr_reg  <= bus.caddr[win_idx];
                        data_reg  <= bus.cstore[win_idx];
                        timer_reg <= '0;
                        state_reg <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    if (finish) begin
                        rr_ptr_reg <= next_ptr;
                        state_reg  <= ARB_IDLE;
                    end else if (timer_reg != TW'(TMAX)) begin
                        // Saturating count of stalled cycles.
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                default: begin
                    state_reg <= ARB_IDLE;
                end
            endcase
        end
    end

    // Memory command comes only from the latched copy so requester changes
    // during ACCESS cannot disturb it.
    assign bus.dREN        = in_access && (op_reg == OP_READ);
    assign bus.dWEN        = in_access && (op_reg == OP_WRITE);
    assign bus.daddr       = in_access ? addr_reg : '0;
    assign bus.dstore      = in_access ? data_reg : '0;
    assign bus.grant       = grant_reg;
    assign bus.timeout_err = abort;

    // Response path is combinational so the owner sees completion in the
    // same cycle memory drops dwait.
    always_comb begin
        bus.cwait = '1;
        bus.cload = '0;
        if (finish) begin
            bus.cwait[grant_reg] = 1'b0;
            if (abort) begin
                bus.cload[grant_reg] = TIMEOUT_DATA;
            end else if (op_reg == OP_READ) begin
                bus.cload[grant_reg] = bus.dload;
            end
        end
    end

endmodule

// File: tb/tb_bus_mem_arbiter.sv
// Directed bench for bus_mem_arbiter. Two instances share clock and reset:
//   u_rr  round-robin, 8-cycle watchdog
//   u_fp  fixed priority, watchdog off
module tb_bus_mem_arbiter;
    import cpu_types_pkg::*;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    bus_arb_if #(.CPUS(2)) bus_rr ();
    bus_arb_if #(.CPUS(2)) bus_fp ();

    bus_mem_arbiter #(.CPUS(2), .RR_MODE(1), .TIMEOUT(8)) u_rr (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_rr)
    );

    bus_mem_arbiter #(.CPUS(2), .RR_MODE(0), .TIMEOUT(0)) u_fp (
        .CLK (CLK),
        .RST (RST),
        .bus (bus_fp)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        bus_rr.cREN = '0; bus_rr.cWEN = '0; bus_rr.caddr = '0; bus_rr.cstore = '0;
        bus_rr.dwait = 1'b0; bus_rr.dload = '0;
        bus_fp.cREN = '0; bus_fp.cWEN = '0; bus_fp.caddr = '0; bus_fp.cstore = '0;
        bus_fp.dwait = 1'b0; bus_fp.dload = '0;
    endtask

    initial begin
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        int          exp_rr;

        // ---------------- reset ----------------
        RST = 1'b1;
        idle_inputs();
        #2;
        check("rst_cwait", {30'd0, bus_rr.cwait}, 32'h3);
        check("rst_dren", {31'd0, bus_rr.dREN}, 32'h0);
        check("rst_dwen", {31'd0, bus_rr.dWEN}, 32'h0);
        check("rst_daddr", bus_rr.daddr, 32'h0);
        check("rst_grant", {31'd0, bus_rr.grant}, 32'h0);
        check("rst_cload0", bus_rr.cload[0], 32'h0);
        check("rst_terr", {31'd0, bus_rr.timeout_err}, 32'h0);
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;

        // ---------------- single read, 3 stall cycles ----------------
        bus_rr.cREN[0] = 1'b1;
        bus_rr.caddr[0] = 32'h40;
        bus_rr.dwait = 1'b1;
        settle();
        check("rd_c0_dren", {31'd0, bus_rr.dREN}, 32'h0);
        tick();
        for (int c = 1; c <= 3; c++) begin
            settle();
            check("rd_stall_dren", {31'd0, bus_rr.dREN}, 32'h1);
            check("rd_stall_daddr", bus_rr.daddr, 32'h40);
            check("rd_stall_cwait", {30'd0, bus_rr.cwait}, 32'h3);
            tick();
        end
        bus_rr.dwait = 1'b0;
        bus_rr.dload = 32'hDEADBEEF;
        bus_rr.cREN = '0;
        settle();
        check("rd_done_cwait", {30'd0, bus_rr.cwait}, 32'h2);
        check("rd_done_cload0", bus_rr.cload[0], 32'hDEADBEEF);
        check("rd_done_cload1", bus_rr.cload[1], 32'h0);
        $display("txn single_read grant=%0d cload=%08h", bus_rr.grant, bus_rr.cload[0]);
        tick();
        check("rd_after_cwait", {30'd0, bus_rr.cwait}, 32'h3);
        check("rd_after_dren", {31'd0, bus_rr.dREN}, 32'h0);

        // ---------------- simultaneous writes: RR alternates, FP starves ch1 ----------------
        // rr pointer is 1 after the read on ch0.
        bus_rr.dload = '0;
        bus_rr.cWEN = 2'b11; bus_fp.cWEN = 2'b11;
        bus_rr.caddr[0] = 32'h100; bus_rr.cstore[0] = 32'hA0;
        bus_rr.caddr[1] = 32'h200; bus_rr.cstore[1] = 32'hB1;
        bus_fp.caddr[0] = 32'h100; bus_fp.cstore[0] = 32'hA0;
        bus_fp.caddr[1] = 32'h200; bus_fp.cstore[1] = 32'hB1;
        for (int t = 0; t < 4; t++) begin
            settle();
            check("sim_idle_rr_dwen", {31'd0, bus_rr.dWEN}, 32'h0);
            check("sim_idle_fp_dwen", {31'd0, bus_fp.dWEN}, 32'h0);
            tick();
            exp_rr   = (t % 2 == 0) ? 1 : 0;
            exp_addr = (exp_rr == 1) ? 32'h200 : 32'h100;
            exp_data = (exp_rr == 1) ? 32'hB1 : 32'hA0;
            if (t == 3) begin
                bus_rr.cWEN = '0;
                bus_fp.cWEN = '0;
            end
            settle();
            check("sim_rr_grant", {31'd0, bus_rr.grant}, exp_rr);
            check("sim_rr_dwen", {31'd0, bus_rr.dWEN}, 32'h1);
            check("sim_rr_daddr", bus_rr.daddr, exp_addr);
            check("sim_rr_dstore", bus_rr.dstore, exp_data);
            check("sim_rr_cwait", {30'd0, bus_rr.cwait}, (exp_rr == 1) ? 32'h1 : 32'h2);
            check("sim_fp_grant", {31'd0, bus_fp.grant}, 32'h0);
            check("sim_fp_daddr", bus_fp.daddr, 32'h100);
            check("sim_fp_cwait", {30'd0, bus_fp.cwait}, 32'h2);
            $display("txn sim%0d rr_grant=%0d fp_grant=%0d", t, bus_rr.grant, bus_fp.grant);
            tick();
        end

        // ---------------- request dropped / address changed mid-ACCESS ----------------
        bus_rr.cREN[1] = 1'b1;
        bus_rr.caddr[1] = 32'h80;
        bus_rr.dwait = 1'b1;
        tick();
        bus_rr.cREN = 2'b01;
        bus_rr.caddr[1] = 32'hFFC;
        bus_rr.caddr[0] = 32'h44;
        settle();
        check("drop_grant", {31'd0, bus_rr.grant}, 32'h1);
        check("drop_daddr", bus_rr.daddr, 32'h80);
        check("drop_dren", {31'd0, bus_rr.dREN}, 32'h1);
        tick();
        bus_rr.dwait = 1'b0;
        bus_rr.dload = 32'h12345678;
        settle();
        check("drop_daddr2", bus_rr.daddr, 32'h80);
        check("drop_cwait", {30'd0, bus_rr.cwait}, 32'h1);
        check("drop_cload1", bus_rr.cload[1], 32'h12345678);
        $display("txn drop grant=%0d daddr=%08h", bus_rr.grant, bus_rr.daddr);
        tick();
        tick();
        bus_rr.dload = 32'hCAFE0044;
        bus_rr.cREN = '0;
        settle();
        check("next_grant", {31'd0, bus_rr.grant}, 32'h0);
        check("next_daddr", bus_rr.daddr, 32'h44);
        check("next_cwait", {30'd0, bus_rr.cwait}, 32'h2);
        check("next_cload0", bus_rr.cload[0], 32'hCAFE0044);
        $display("txn next grant=%0d daddr=%08h", bus_rr.grant, bus_rr.daddr);
        tick();

        // ---------------- watchdog abort (rr) / no watchdog (fp) ----------------
        bus_rr.dload = '0;
        bus_rr.cWEN[1] = 1'b1; bus_rr.caddr[1] = 32'h300; bus_rr.cstore[1] = 32'h55;
        bus_rr.dwait = 1'b1;
        bus_fp.cWEN[0] = 1'b1; bus_fp.caddr[0] = 32'h304; bus_fp.cstore[0] = 32'h66;
        bus_fp.dwait = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) begin
            bus_rr.cWEN = '0;
            bus_fp.cWEN = '0;
            settle();
            if (k < 8) begin
                check("wd_early_terr", {31'd0, bus_rr.timeout_err}, 32'h0);
                check("wd_early_cwait", {30'd0, bus_rr.cwait}, 32'h3);
            end else begin
                check("wd_terr", {31'd0, bus_rr.timeout_err}, 32'h1);
                check("wd_cwait", {30'd0, bus_rr.cwait}, 32'h1);
                check("wd_cload1", bus_rr.cload[1], 32'hBAD1BAD1);
                check("wd_dwen", {31'd0, bus_rr.dWEN}, 32'h1);
                check("wd_dstore", bus_rr.dstore, 32'h55);
                check("fp_noterr", {31'd0, bus_fp.timeout_err}, 32'h0);
                check("fp_nocwait", {30'd0, bus_fp.cwait}, 32'h3);
                $display("txn watchdog terr=%0d cload=%08h", bus_rr.timeout_err, bus_rr.cload[1]);
            end
            tick();
        end
        settle();
        check("wd_after_dwen", {31'd0, bus_rr.dWEN}, 32'h0);
        check("wd_after_terr", {31'd0, bus_rr.timeout_err}, 32'h0);
        check("fp_still_dwen", {31'd0, bus_fp.dWEN}, 32'h1);
        bus_fp.dwait = 1'b0;
        settle();
        check("fp_done_cwait", {30'd0, bus_fp.cwait}, 32'h2);
        check("fp_done_cload", bus_fp.cload[0], 32'h0);
        tick();

        // ---------------- completion on the last allowed cycle wins ----------------
        bus_rr.cREN[0] = 1'b1; bus_rr.caddr[0] = 32'h500;
        bus_rr.dwait = 1'b1;
        tick();
        bus_rr.cREN = '0;
        for (int k = 1; k <= 7; k++) begin
            tick();
        end
        bus_rr.dwait = 1'b0;
        bus_rr.dload = 32'h0BADF00D;
        settle();
        check("race_terr", {31'd0, bus_rr.timeout_err}, 32'h0);
        check("race_cwait", {30'd0, bus_rr.cwait}, 32'h2);
        check("race_cload0", bus_rr.cload[0], 32'h0BADF00D);
        $display("txn race grant=%0d cload=%08h", bus_rr.grant, bus_rr.cload[0]);
        tick();
        check("race_after_dren", {31'd0, bus_rr.dREN}, 32'h0);

        // ---------------- async reset mid-ACCESS ----------------
        bus_rr.dload = '0;
        bus_rr.cREN[1] = 1'b1; bus_rr.caddr[1] = 32'h600;
        bus_rr.dwait = 1'b1;
        tick();
        bus_rr.cREN = 2'b11;
        bus_rr.caddr[0] = 32'h700;
        settle();
        check("pre_rst_grant", {31'd0, bus_rr.grant}, 32'h1);
        check("pre_rst_dren", {31'd0, bus_rr.dREN}, 32'h1);
        RST = 1'b1;
        #1;
        check("arst_dren", {31'd0, bus_rr.dREN}, 32'h0);
        check("arst_daddr", bus_rr.daddr, 32'h0);
        check("arst_cwait", {30'd0, bus_rr.cwait}, 32'h3);
        check("arst_grant", {31'd0, bus_rr.grant}, 32'h0);
        #1;
        RST = 1'b0;
        tick();
        bus_rr.cREN = '0;
        bus_rr.dwait = 1'b0;
        bus_rr.dload = 32'h77770000;
        settle();
        check("post_rst_grant", {31'd0, bus_rr.grant}, 32'h0);
        check("post_rst_daddr", bus_rr.daddr, 32'h700);
        check("post_rst_cload0", bus_rr.cload[0], 32'h77770000);
        $display("txn post_reset grant=%0d daddr=%08h", bus_rr.grant, bus_rr.daddr);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
